// File: rtl/lfsr_rand_sched_if.sv
// Request/grant and delivery bundle between the random-number scheduler and its two consumers.
// The scheduler side uses the slave modport; the consumer side uses master.
interface lfsr_rand_sched_if #(
    parameter int WIDTH = 16
);
    logic [1:0]       req;
    logic [1:0]       gnt;
    logic             rnd_valid;
    logic [WIDTH-1:0] rnd_data;
    logic             rnd_id;

    modport master (
        output req,
        input  gnt, rnd_valid, rnd_data, rnd_id
    );

    modport slave (
        input  req,
        output gnt, rnd_valid, rnd_data, rnd_id
    );
endinterface

// File: rtl/lfsr_rand_sched.sv
// Round-robin scheduler for two consumers sharing a 16-bit Galois LFSR.
// The LFSR advances STEPS times per served word; all outputs are registered.
module lfsr_rand_sched #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
    parameter logic [WIDTH-1:0] SEED  = 16'hACE1,
    parameter int               STEPS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                seed_load,
    input  logic [WIDTH-1:0]    seed_in,
    lfsr_rand_sched_if.slave    bus,
    output logic                busy,
    output logic [WIDTH-1:0]    lfsr_state
);
    typedef enum logic [1:0] {IDLE, ADVANCE, DELIVER} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             prio_q, prio_d;
    logic             win_q, win_d;
    logic             win_sel;
    logic [1:0]       gnt_q, gnt_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             id_q, id_d;
    logic             busy_q, busy_d;

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : '0);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lfsr_q  <= SEED;
            cnt_q   <= '0;
            prio_q  <= 1'b0;
            win_q   <= 1'b0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            id_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            prio_q  <= prio_d;
            win_q   <= win_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            id_q    <= id_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        case (bus.req)
            2'b01:   win_sel = 1'b0;
            2'b10:   win_sel = 1'b1;
            default: win_sel = prio_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        prio_d  = prio_q;
        win_d   = win_q;
        gnt_d   = gnt_q;
        valid_d = 1'b0;
        data_d  = data_q;
        id_d    = id_q;

        case (state_q)
            IDLE: begin
                if (seed_load) begin
                    lfsr_d = (seed_in == '0) ? SEED : seed_in;
                end else if (bus.req != 2'b00) begin
                    state_d = ADVANCE;
                    win_d   = win_sel;
                    gnt_d   = win_sel ? 2'b10 : 2'b01;
                    cnt_d   = 4'(STEPS);
                end
            end
            ADVANCE: begin
                // A zero register would lock up, so reseed; the cycle still counts as a step.
                lfsr_d = (lfsr_q == '0) ? SEED : lfsr_step(lfsr_q);
                cnt_d  = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    // Capture the final word now so rnd_data/rnd_valid are registered in DELIVER.
                    state_d = DELIVER;
                    valid_d = 1'b1;
                    data_d  = lfsr_d;
                    id_d    = win_q;
                end
            end
            DELIVER: begin
                state_d = IDLE;
                gnt_d   = '0;
                prio_d  = ~win_q;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.gnt       = gnt_q;
    assign bus.rnd_valid = valid_q;
    assign bus.rnd_data  = data_q;
    assign bus.rnd_id    = id_q;
    assign busy          = busy_q;
    assign lfsr_state    = lfsr_q;
endmodule

// File: tb/tb_lfsr_rand_sched.sv
// Directed bench for lfsr_rand_sched: one instance with STEPS=4, one with STEPS=1.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_lfsr_rand_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        seed_load4 = 1'b0;
    logic [15:0] seed_in4 = '0;
    logic        busy4;
    logic [15:0] lfsr4;
    logic        seed_load1 = 1'b0;
    logic [15:0] seed_in1 = '0;
    logic        busy1;
    logic [15:0] lfsr1;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    lfsr_rand_sched_if #(.WIDTH(16)) bus4 ();
    lfsr_rand_sched_if #(.WIDTH(16)) bus1 ();

    lfsr_rand_sched #(.WIDTH(16), .TAPS(16'hB400), .SEED(16'hACE1), .STEPS(4)) u_dut4 (
        .clk        (clk),
        .rst        (rst),
        .seed_load  (seed_load4),
        .seed_in    (seed_in4),
        .bus        (bus4.slave),
        .busy       (busy4),
        .lfsr_state (lfsr4)
    );

    lfsr_rand_sched #(.WIDTH(16), .TAPS(16'hB400), .SEED(16'hACE1), .STEPS(1)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .seed_load  (seed_load1),
        .seed_in    (seed_in1),
        .bus        (bus1.slave),
        .busy       (busy1),
        .lfsr_state (lfsr1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        logic [1:0]  e_gnt   [1:6];
        logic        e_busy  [1:6];
        logic        e_valid [1:6];
        logic [15:0] e_lfsr  [1:6];
        int unsigned ids [4];
        int unsigned at  [4];
        int unsigned got;
        int unsigned both;
        int unsigned pulses;

        bus4.req = 2'b00;
        bus1.req = 2'b00;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();

        // Reset state
        check("rst_gnt",   32'(bus4.gnt), 32'h0);
        check("rst_valid", 32'(bus4.rnd_valid), 32'h0);
        check("rst_data",  32'(bus4.rnd_data), 32'h0);
        check("rst_id",    32'(bus4.rnd_id), 32'h0);
        check("rst_busy",  32'(busy4), 32'h0);
        check("rst_lfsr",  32'(lfsr4), 32'hACE1);
        check("rst_lfsr1", 32'(lfsr1), 32'hACE1);

        // Single request, one IDLE cycle, STEPS=4
        e_gnt   = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
        e_busy  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        e_valid = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        e_lfsr  = '{16'hACE1, 16'hE270, 16'h7138, 16'h389C, 16'h1C4E, 16'h1C4E};
        bus4.req = 2'b01;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            bus4.req = 2'b00;
            check($sformatf("s1_gnt%0d", k),   32'(bus4.gnt), 32'(e_gnt[k]));
            check($sformatf("s1_busy%0d", k),  32'(busy4), 32'(e_busy[k]));
            check($sformatf("s1_valid%0d", k), 32'(bus4.rnd_valid), 32'(e_valid[k]));
            check($sformatf("s1_lfsr%0d", k),  32'(lfsr4), 32'(e_lfsr[k]));
        end
        check("s1_data", 32'(bus4.rnd_data), 32'h1C4E);
        check("s1_id",   32'(bus4.rnd_id), 32'h0);

        // Zero seed falls back to SEED
        seed_load4 = 1'b1;
        seed_in4   = 16'h0000;
        cyc();
        seed_load4 = 1'b0;
        check("zseed_lfsr", 32'(lfsr4), 32'hACE1);

        // seed_load during ADVANCE is dropped
        bus4.req = 2'b01;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            bus4.req   = 2'b00;
            seed_load4 = (k == 2);
            seed_in4   = 16'h1234;
            check($sformatf("adv_lfsr%0d", k), 32'(lfsr4), 32'(e_lfsr[k]));
            check($sformatf("adv_valid%0d", k), 32'(bus4.rnd_valid), 32'(e_valid[k]));
        end
        check("adv_data", 32'(bus4.rnd_data), 32'h1C4E);
        check("adv_id",   32'(bus4.rnd_id), 32'h0);

        // seed_load and req in the same IDLE cycle: load wins, grant one cycle later
        seed_load4 = 1'b1;
        seed_in4   = 16'h0001;
        bus4.req   = 2'b01;
        cyc();
        seed_load4 = 1'b0;
        check("sl_gnt_t1",  32'(bus4.gnt), 32'h0);
        check("sl_lfsr_t1", 32'(lfsr4), 32'h0001);
        cyc();
        bus4.req = 2'b00;
        check("sl_gnt_t2", 32'(bus4.gnt), 32'h1);
        repeat (4) cyc();
        check("sl_valid", 32'(bus4.rnd_valid), 32'h1);
        check("sl_data",  32'(bus4.rnd_data), 32'h1680);
        cyc();
        check("sl_busy_after", 32'(busy4), 32'h0);

        // Reset in the second ADVANCE cycle aborts the service
        bus4.req = 2'b01;
        cyc();
        bus4.req = 2'b00;
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("ab_gnt",  32'(bus4.gnt), 32'h0);
        check("ab_busy", 32'(busy4), 32'h0);
        check("ab_lfsr", 32'(lfsr4), 32'hACE1);
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (bus4.rnd_valid) pulses++;
        end
        check("ab_no_valid", pulses, 0);

        // Both requesting: alternate 0,1,0,1 with a 6-cycle service period
        got  = 0;
        both = 0;
        bus4.req = 2'b11;
        for (int i = 1; i <= 40 && got < 4; i++) begin
            cyc();
            if (bus4.gnt == 2'b11) both++;
            if (bus4.rnd_valid) begin
                ids[got] = 32'(bus4.rnd_id);
                at[got]  = i;
                got++;
            end
        end
        bus4.req = 2'b00;
        check("rr_count", got, 4);
        check("rr_both_gnt", both, 0);
        for (int j = 0; j < 4; j++) begin
            if (j < got) begin
                check($sformatf("rr_id%0d", j), ids[j], j % 2);
                check($sformatf("rr_at%0d", j), at[j], 5 + 6 * j);
            end
        end
        repeat (8) cyc();

        // STEPS=1: seed 0001 then requester 1
        seed_load1 = 1'b1;
        seed_in1   = 16'h0001;
        cyc();
        seed_load1 = 1'b0;
        check("s1x_lfsr", 32'(lfsr1), 32'h0001);
        bus1.req = 2'b10;
        cyc();
        bus1.req = 2'b00;
        check("s1x_gnt",   32'(bus1.gnt), 32'h2);
        check("s1x_busy",  32'(busy1), 32'h1);
        check("s1x_valid0", 32'(bus1.rnd_valid), 32'h0);
        cyc();
        check("s1x_valid", 32'(bus1.rnd_valid), 32'h1);
        check("s1x_data",  32'(bus1.rnd_data), 32'hB400);
        check("s1x_id",    32'(bus1.rnd_id), 32'h1);
        cyc();
        check("s1x_idle",  32'(busy1), 32'h0);
        check("s1x_gnt0",  32'(bus1.gnt), 32'h0);
        check("s1x_hold",  32'(bus1.rnd_data), 32'hB400);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/lfsr_rand_sched.md
# lfsr_rand_sched

Shared random-number scheduler built around a 16-bit Galois LFSR. It arbitrates two requesters with a round-robin policy and advances the LFSR a configurable number of steps per served word, which decorrelates consecutive outputs. It also handles seed loading and zero-state lockup recovery. It sits between the Galois LFSR datapath and its consumers, replacing free-running use of the LFSR output.

## Interface
- WIDTH, 16: LFSR and data width.
- TAPS, 16'hB400: Galois feedback mask (x^16+x^14+x^13+x^11+1, maximal length).
- SEED, 16'hACE1: reset and fallback seed; must be non-zero.
- STEPS, 4: LFSR steps per served word; legal range 1..15.

- clk  in  1  single clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- seed_load  in  1  load seed_in into the LFSR; honoured only in IDLE.
- seed_in  in  WIDTH  new seed.
- req  in  2  per-requester request level; sampled only in IDLE.
- gnt  out  2  one-hot grant; held from ADVANCE entry through DELIVER.
- rnd_valid  out  1  one-cycle pulse: rnd_data/rnd_id are valid.
- rnd_data  out  WIDTH  delivered random word; holds its value between deliveries.
- rnd_id  out  1  index of the served requester.
- busy  out  1  high whenever state != IDLE.
- lfsr_state  out  WIDTH  current LFSR register.

## Operation
- LFSR step: s_next = (s >> 1) ^ (s[0] ? TAPS : 0).
- LFSR advances only in ADVANCE. In all other states it holds.
- FSM states: IDLE, ADVANCE, DELIVER.
- IDLE transitions:
  - seed_load=1: lfsr <= (seed_in==0 ? SEED : seed_in); stay in IDLE.
  - seed_load has priority over req in the same cycle. req is served on a later IDLE cycle if still asserted.
  - Else if req!=0: go to ADVANCE; gnt <= one-hot(winner); cnt <= STEPS.
- Arbitration:
  - Only one bit of req set: that requester wins.
  - Both bits set: winner = prio.
  - prio <= ~winner on exit from DELIVER.
- ADVANCE:
  - Each cycle: lfsr steps and cnt decrements.
  - When cnt==1: go to DELIVER.
  - Lockup guard: if lfsr==0 at any ADVANCE cycle, lfsr <= SEED instead of stepping. The step still counts toward cnt.
- DELIVER (exactly 1 cycle): rnd_valid=1, rnd_data=lfsr, rnd_id=winner. Then gnt <= 0 and go to IDLE.
- Requests are not revalidated mid-service. Dropping req after grant still completes the delivery.
- seed_load outside IDLE is ignored (dropped, not queued).
- Reset values:
  - lfsr=SEED, state=IDLE, cnt=0, prio=0.
  - gnt=0, rnd_valid=0, rnd_data=0, rnd_id=0, busy=0.
- rst mid-service aborts the service: no rnd_valid, prio returns to 0.

## Timing
- All outputs are registered.
- req seen in IDLE at cycle t:
  - gnt and busy high from t+1.
  - ADVANCE occupies cycles t+1..t+STEPS.
  - rnd_valid is high in cycle t+STEPS+1.
  - IDLE again at t+STEPS+2.
- Latency req->rnd_valid = STEPS+1 cycles.
- Service period = STEPS+2 cycles.
- Back-to-back: a requester holding req continuously is re-granted on the first IDLE cycle. With both requesters requesting, grants alternate 0,1,0,1 starting with 0 after reset.
- rnd_data equals lfsr_state during the DELIVER cycle. lfsr_state is unchanged in IDLE and DELIVER.

## Test plan
- Reset, STEPS=4, req=2'b01 held one IDLE cycle:
  - gnt=01 for 5 cycles.
  - rnd_valid at t+5 with rnd_data=16'h1C4E, rnd_id=0.
  - busy low at t+6.
- STEPS=1, seed_load with seed_in=16'h0001, then req=2'b10: rnd_data=16'hB400, rnd_id=1, latency 2 cycles.
- seed_load with seed_in=0 in IDLE: lfsr_state=16'hACE1 next cycle. seed_load pulsed during ADVANCE: lfsr_state sequence unaffected.
- req=2'b11 held for 4 services: rnd_id sequence 0,1,0,1. gnt never has both bits set.
- rst asserted in the 2nd ADVANCE cycle: next cycle shows state IDLE, gnt=0, lfsr_state=16'hACE1, and no rnd_valid ever issued for that request.
- seed_load=1 and req=2'b01 in the same IDLE cycle: seed loaded first, grant follows one cycle later. Delivered word equals STEPS Galois steps from seed_in.
